// File: rtl/pipeline_hazard_ctrl.sv
// Purpose: stall/flush controller for the IF/DC front end (load-use hazards, branch/trap redirects).
// Latency: load-use stall is combinational (0 cycles); flushOut rises the cycle after a redirect is sampled.
// Backpressure: extStall stalls IF/DC, parks a redirect in PEND until it drops, and freezes the load-use counter.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   dcValid, dcRs1, dcRs2           decode-stage instruction and its source registers
//   exValid, exIsLoad, exRd         EX-stage instruction, load flag, destination register
//   brRedirect, brTarget            branch/jump redirect request and target PC
//   trapReq, trapVector             trap request and vector PC (wins over a branch)
//   extStall                        memory/fetch back-pressure
//   stallOut, flushOut, bubbleOut   hold IF/DC, flush IF/DC, inject NOP into EX
//   flushAddrOut                    refetch PC, valid while flushOut=1
//   stallCount                      saturating count of cycles with stallOut=1
module pipeline_hazard_ctrl #(
    parameter int width        = 32,
    parameter int rsWidth      = 5,
    parameter int LOAD_LATENCY = 1,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               dcValid,
    input  logic [rsWidth-1:0] dcRs1,
    input  logic [rsWidth-1:0] dcRs2,
    input  logic               exValid,
    input  logic               exIsLoad,
    input  logic [rsWidth-1:0] exRd,
    input  logic               brRedirect,
    input  logic [width-1:0]   brTarget,
    input  logic               trapReq,
    input  logic [width-1:0]   trapVector,
    input  logic               extStall,
    output logic               stallOut,
    output logic               flushOut,
    output logic [width-1:0]   flushAddrOut,
    output logic               bubbleOut,
    output logic [15:0]        stallCount
);

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        FLUSH   = 2'd2,
        PEND    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [width-1:0]   addr_q, addr_d;
    // Remembers whether the latched address is a trap vector, so that a later
    // branch arriving while parked in PEND cannot overwrite it.
    logic               from_trap_q, from_trap_d;
    logic [15:0]        stall_cnt_q;

    logic               stall_c, flush_c, bubble_c;
    logic               redirect;
    logic [width-1:0]   redir_addr;
    logic               hit;

    assign redirect   = trapReq | brRedirect;
    assign redir_addr = trapReq ? trapVector : brTarget;
    assign hit        = dcValid & exValid & exIsLoad & (exRd != '0)
                      & ((dcRs1 == exRd) | (dcRs2 == exRd));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        from_trap_d = from_trap_q;
        stall_c     = 1'b0;
        flush_c     = 1'b0;
        bubble_c    = 1'b0;

        case (state_q)
            RUN: begin
                // A redirect makes the dependent decode instruction dead, so it
                // takes priority over any load-use stall in the same cycle.
                if (redirect) begin
                    addr_d      = redir_addr;
                    from_trap_d = trapReq;
                    if (extStall) begin
                        state_d = PEND;
                    end else begin
                        state_d = FLUSH;
                        cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                    end
                end else if (hit) begin
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                    // This cycle is the first stall cycle; LDSTALL covers the rest.
                    if (LOAD_LATENCY > 1) begin
                        state_d = LDSTALL;
                        cnt_d   = CNT_W'(LOAD_LATENCY - 2);
                    end
                end else if (extStall) begin
                    stall_c = 1'b1;
                end
            end

            LDSTALL: begin
                stall_c  = 1'b1;
                bubble_c = 1'b1;
                if (redirect) begin
                    addr_d      = redir_addr;
                    from_trap_d = trapReq;
                    if (extStall) begin
                        state_d = PEND;
                    end else begin
                        state_d = FLUSH;
                        cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                    end
                end else if (!extStall) begin
                    if (cnt_q == '0) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end

            FLUSH: begin
                // Flush wins over every stall source: the IF/DC contents are discarded anyway.
                flush_c  = 1'b1;
                bubble_c = 1'b1;
                if (redirect) begin
                    addr_d      = redir_addr;
                    from_trap_d = trapReq;
                    cnt_d       = CNT_W'(FLUSH_CYCLES - 1);
                end else if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            PEND: begin
                stall_c = 1'b1;
                if (trapReq) begin
                    addr_d      = trapVector;
                    from_trap_d = 1'b1;
                end else if (brRedirect && !from_trap_q) begin
                    addr_d = brTarget;
                end
                if (!extStall) begin
                    state_d = FLUSH;
                    cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                end
            end

            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            addr_q      <= '0;
            from_trap_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            from_trap_q <= from_trap_d;
            if (stall_c && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    // Control outputs are forced low for the whole reset window.
    assign stallOut     = stall_c  & ~reset;
    assign flushOut     = flush_c  & ~reset;
    assign bubbleOut    = bubble_c & ~reset;
    assign flushAddrOut = addr_q;
    assign stallCount   = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Purpose: directed self-checking bench for pipeline_hazard_ctrl (default build plus a
// LOAD_LATENCY=3 / FLUSH_CYCLES=1 build sharing the same stimulus).
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        dcValid;
    logic [4:0]  dcRs1, dcRs2;
    logic        exValid, exIsLoad;
    logic [4:0]  exRd;
    logic        brRedirect;
    logic [31:0] brTarget;
    logic        trapReq;
    logic [31:0] trapVector;
    logic        extStall;

    logic        stallOut, flushOut, bubbleOut;
    logic [31:0] flushAddrOut;
    logic [15:0] stallCount;

    logic        stall3, flush3, bubble3;
    logic [31:0] addr3;
    logic [15:0] sc3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl u_dut (
        .clk(clk), .reset(reset),
        .dcValid(dcValid), .dcRs1(dcRs1), .dcRs2(dcRs2),
        .exValid(exValid), .exIsLoad(exIsLoad), .exRd(exRd),
        .brRedirect(brRedirect), .brTarget(brTarget),
        .trapReq(trapReq), .trapVector(trapVector),
        .extStall(extStall),
        .stallOut(stallOut), .flushOut(flushOut), .flushAddrOut(flushAddrOut),
        .bubbleOut(bubbleOut), .stallCount(stallCount)
    );

    pipeline_hazard_ctrl #(.LOAD_LATENCY(3), .FLUSH_CYCLES(1)) u_dut3 (
        .clk(clk), .reset(reset),
        .dcValid(dcValid), .dcRs1(dcRs1), .dcRs2(dcRs2),
        .exValid(exValid), .exIsLoad(exIsLoad), .exRd(exRd),
        .brRedirect(brRedirect), .brTarget(brTarget),
        .trapReq(trapReq), .trapVector(trapVector),
        .extStall(extStall),
        .stallOut(stall3), .flushOut(flush3), .flushAddrOut(addr3),
        .bubbleOut(bubble3), .stallCount(sc3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        dcValid = 0; dcRs1 = 0; dcRs2 = 0;
        exValid = 0; exIsLoad = 0; exRd = 0;
        brRedirect = 0; brTarget = 0;
        trapReq = 0; trapVector = 0;
        extStall = 0;
    endtask

    task automatic set_hit(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        dcValid = 1; dcRs1 = rs1; dcRs2 = rs2;
        exValid = 1; exIsLoad = 1; exRd = rd;
    endtask

    initial begin
        // Reset with a live hazard on the inputs: outputs must stay low.
        clear_inputs();
        reset = 1;
        set_hit(5'd5, 5'd0, 5'd5);
        tick(); tick();
        check("rst_stall", stallOut, 0);
        check("rst_flush", flushOut, 0);
        check("rst_bubble", bubbleOut, 0);
        reset = 0;
        clear_inputs();
        tick();
        check("rst_count", stallCount, 0);
        check("rst_addr", flushAddrOut, 0);
        check("rst_idle_stall", stallOut, 0);

        // Load x5 in EX, decode reads x5 via rs1.
        set_hit(5'd5, 5'd0, 5'd5);
        #1;
        check("lu_stall", stallOut, 1);
        check("lu_bubble", bubbleOut, 1);
        check("lu3_stall_c0", stall3, 1);
        check("lu3_bubble_c0", bubble3, 1);
        tick();
        exIsLoad = 0;
        #1;
        check("lu_stall_end", stallOut, 0);
        check("lu_bubble_end", bubbleOut, 0);
        check("lu3_stall_c1", stall3, 1);
        check("lu3_bubble_c1", bubble3, 1);
        tick();
        check("lu3_stall_c2", stall3, 1);
        tick();
        check("lu3_stall_c3", stall3, 0);
        check("lu3_count", sc3, 3);
        check("lu_count", stallCount, 1);

        // rs2 match, then no-valid and x0 cases.
        set_hit(5'd3, 5'd7, 5'd7);
        #1;
        check("lu_rs2_stall", stallOut, 1);
        tick();
        dcValid = 0;
        #1;
        check("lu_novalid", stallOut, 0);
        tick();
        set_hit(5'd0, 5'd0, 5'd0);
        #1;
        check("lu_x0_stall", stallOut, 0);
        tick();
        check("lu_x0_count", stallCount, 2);
        clear_inputs();
        tick(); tick();

        // Branch redirect to 0x100: two flush cycles, flush beats extStall.
        brRedirect = 1; brTarget = 32'h100;
        #1;
        check("br_flush_c0", flushOut, 0);
        check("br_stall_c0", stallOut, 0);
        tick();
        brRedirect = 0; extStall = 1;
        #1;
        check("br_flush_c1", flushOut, 1);
        check("br_addr_c1", flushAddrOut, 32'h100);
        check("br_stall_c1", stallOut, 0);
        check("br_bubble_c1", bubbleOut, 1);
        check("br3_flush_c1", flush3, 1);
        check("br3_addr_c1", addr3, 32'h100);
        tick();
        extStall = 0;
        #1;
        check("br_flush_c2", flushOut, 1);
        check("br3_flush_c2", flush3, 0);
        tick();
        check("br_flush_c3", flushOut, 0);
        check("br_addr_hold", flushAddrOut, 32'h100);

        // Trap and branch together: trap vector wins.
        trapReq = 1; trapVector = 32'h80; brRedirect = 1; brTarget = 32'h100;
        tick();
        clear_inputs();
        #1;
        check("trap_flush", flushOut, 1);
        check("trap_addr", flushAddrOut, 32'h80);
        tick(); tick();
        check("trap_done", flushOut, 0);

        // Redirect and load-use hazard together: redirect wins, no stall.
        set_hit(5'd9, 5'd0, 5'd9);
        brRedirect = 1; brTarget = 32'h140;
        #1;
        check("rh_stall", stallOut, 0);
        check("rh_bubble", bubbleOut, 0);
        tick();
        clear_inputs();
        #1;
        check("rh_addr", flushAddrOut, 32'h140);
        check("rh_flush", flushOut, 1);
        tick(); tick();

        // Trap parked in PEND: a later branch must not displace it.
        trapReq = 1; trapVector = 32'h80; extStall = 1;
        #1;
        check("pt_stall_c0", stallOut, 0);
        tick();
        trapReq = 0; brRedirect = 1; brTarget = 32'h300;
        #1;
        check("pt_stall_c1", stallOut, 1);
        check("pt_flush_c1", flushOut, 0);
        check("pt_addr_c1", flushAddrOut, 32'h80);
        tick();
        brRedirect = 0; extStall = 0;
        #1;
        check("pt_stall_c2", stallOut, 1);
        check("pt_addr_c2", flushAddrOut, 32'h80);
        tick();
        check("pt_flush_c3", flushOut, 1);
        check("pt_addr_c3", flushAddrOut, 32'h80);
        tick(); tick();

        // Branch 0x200 parked for 3 cycles of extStall, replaced by 0x300.
        brRedirect = 1; brTarget = 32'h200; extStall = 1;
        tick();
        brRedirect = 0;
        #1;
        check("pb_stall_c1", stallOut, 1);
        check("pb_flush_c1", flushOut, 0);
        check("pb_addr_c1", flushAddrOut, 32'h200);
        tick();
        brRedirect = 1; brTarget = 32'h300;
        tick();
        brRedirect = 0; extStall = 0;
        #1;
        check("pb_stall_c3", stallOut, 1);
        check("pb_addr_c3", flushAddrOut, 32'h300);
        tick();
        check("pb_flush_c4", flushOut, 1);
        check("pb_addr_c4", flushAddrOut, 32'h300);
        check("pb_stall_c4", stallOut, 0);
        tick();
        check("pb_flush_c5", flushOut, 1);
        tick();
        check("pb_flush_c6", flushOut, 0);
        check("pb_count", stallCount, 7);

        // Reset in the middle of a flush.
        brRedirect = 1; brTarget = 32'h180;
        tick();
        clear_inputs();
        #1;
        check("rf_flush_pre", flushOut, 1);
        reset = 1;
        #1;
        check("rf_flush_inreset", flushOut, 0);
        tick();
        reset = 0;
        #1;
        check("rf_flush_post", flushOut, 0);
        check("rf_addr_post", flushAddrOut, 0);
        check("rf_count_post", stallCount, 0);

        // Saturating stall counter.
        extStall = 1;
        #1;
        check("sat_stall", stallOut, 1);
        repeat (10) tick();
        check("sat_count_10", stallCount, 10);
        repeat (65525) tick();
        check("sat_count_max", stallCount, 16'hFFFF);
        repeat (5) tick();
        check("sat_count_hold", stallCount, 16'hFFFF);
        extStall = 0;
        #1;
        check("sat_release", stallOut, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
